// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scanout path: counter limits, RGB332 field
// positions, the fetch FSM encoding and a byte-select helper.
package vga_pkg;

  localparam int H_COUNT_MAX = 1023;
  localparam int V_COUNT_MAX = 767;

  // RGB332 field positions inside one pixel byte
  localparam int RED_HI   = 7;
  localparam int RED_LO   = 5;
  localparam int GREEN_HI = 4;
  localparam int GREEN_LO = 2;
  localparam int BLUE_HI  = 1;
  localparam int BLUE_LO  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Pixel 0 sits in the least significant byte of a framebuffer word.
  function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                           input logic [1:0]  sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous 32-bit prefetch FIFO; flush empties it and overrides push/pop.
// Head word is presented combinationally on data.
module scanout_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        c,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        push,
  input  logic [31:0]                 push_data,
  input  logic                        pop,
  output logic [31:0]                 data,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL_COUNT) || do_pop);
  assign data    = mem[rd_ptr];

  always_ff @(posedge c) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge c) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: prefetches 32-bit words into a FIFO, unpacks four
// RGB332 pixels per word and emits colour/de/syncs two cycles after the counters.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int         H_ACTIVE        = 800,
  parameter int         V_ACTIVE        = 600,
  parameter int         ADDR_W          = 20,
  parameter int         FIFO_DEPTH      = 8,
  parameter logic [7:0] UNDERFLOW_COLOR = 8'hE3
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic [9:0]        counterX,
  input  logic [9:0]        counterY,
  input  logic              hSync_in,
  input  logic              vSync_in,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              de,
  output logic              hSync_out,
  output logic              vSync_out,
  output logic              underflow,
  output state_t            fsm_state
);

  // Memory port handshake: a request transfers on a cycle where mem_req and
  // mem_ready are both high; mem_addr holds while mem_req waits for mem_ready.
  // Responses arrive in order, one word per mem_rvalid cycle, no back-pressure.

  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int WL_W = 20;
  localparam logic [WL_W-1:0] FRAME_WORDS = WL_W'(H_ACTIVE * V_ACTIVE / 4);
  localparam logic [CW:0]     DEPTH_L     = (CW+1)'(FIFO_DEPTH);

  state_t            state;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     out_next;
  logic [WL_W-1:0]   words_left;
  logic [ADDR_W-1:0] base_q;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       in_flight;
  logic [31:0]       fifo_head;
  logic              fifo_empty;
  logic              fifo_flush;
  logic              fifo_pop;
  logic              frame_end;
  logic              active;
  logic              accept;
  logic              rsp_run;
  logic              drain_hit;
  logic              drain_done;
  logic              run_load;
  logic              run_flush;

  logic              s1_active;
  logic              s1_hs;
  logic              s1_vs;
  logic [7:0]        s1_byte;

  assign frame_end = (counterX == 10'(H_COUNT_MAX)) && (counterY == 10'(V_COUNT_MAX));
  assign active    = ({1'b0, counterX} < 11'(H_ACTIVE)) && ({1'b0, counterY} < 11'(V_ACTIVE));

  // Requested words reserve FIFO space up front, so pushes can never overflow.
  assign in_flight = {1'b0, fifo_count} + {1'b0, outstanding};
  assign mem_req   = (state == RUN) && (words_left != '0) && (in_flight < DEPTH_L);
  assign accept    = mem_req && mem_ready;
  assign rsp_run   = (state == RUN) && mem_rvalid && (outstanding != '0);
  assign out_next  = outstanding + CW'(accept) - CW'(rsp_run);

  // Reads still owed at frame end include one accepted on that very edge.
  assign run_load   = frame_end && ((state == IDLE) || ((state == RUN) && (out_next == '0)));
  assign run_flush  = frame_end && (state == RUN) && (out_next != '0);
  assign drain_hit  = (state == DRAIN) && mem_rvalid && (drop_cnt != '0);
  assign drain_done = (state == DRAIN) && ((drop_cnt == '0) || (drain_hit && (drop_cnt == CW'(1))));

  assign fifo_flush = run_load || run_flush || drain_done;
  assign fifo_pop   = active && (counterX[1:0] == 2'd3) && !fifo_empty;
  assign fsm_state  = state;

  scanout_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .c         (c),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (rsp_run),
    .push_data (mem_rdata),
    .pop       (fifo_pop),
    .data      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state       <= IDLE;
      outstanding <= '0;
      drop_cnt    <= '0;
      words_left  <= '0;
      mem_addr    <= '0;
      base_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_end) begin
            state       <= RUN;
            mem_addr    <= fb_base;
            words_left  <= FRAME_WORDS;
            outstanding <= '0;
          end
        end
        RUN: begin
          if (run_load) begin
            mem_addr    <= fb_base;
            words_left  <= FRAME_WORDS;
            outstanding <= '0;
          end else if (run_flush) begin
            state       <= DRAIN;
            drop_cnt    <= out_next;
            outstanding <= '0;
            base_q      <= fb_base;
          end else begin
            outstanding <= out_next;
            if (accept) begin
              mem_addr   <= mem_addr + 1'b1;
              words_left <= words_left - 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state      <= RUN;
            mem_addr   <= base_q;
            words_left <= FRAME_WORDS;
            drop_cnt   <= '0;
          end else if (drain_hit) begin
            drop_cnt <= drop_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 samples the counters and FIFO head; stage 2 drives the pins.
  always_ff @(posedge c) begin
    if (!rst_n) begin
      s1_active <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_byte   <= '0;
      underflow <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      de        <= 1'b0;
      hSync_out <= 1'b1;
      vSync_out <= 1'b1;
    end else begin
      s1_active <= active;
      s1_hs     <= hSync_in;
      s1_vs     <= vSync_in;
      if (active && !fifo_empty) begin
        s1_byte <= pick_byte(fifo_head, counterX[1:0]);
      end else if (active) begin
        s1_byte   <= UNDERFLOW_COLOR;
        underflow <= 1'b1;
      end else begin
        s1_byte <= '0;
      end
      red       <= s1_byte[RED_HI:RED_LO];
      green     <= s1_byte[GREEN_HI:GREEN_LO];
      blue      <= s1_byte[BLUE_HI:BLUE_LO];
      de        <= s1_active;
      hSync_out <= s1_hs;
      vSync_out <= s1_vs;
    end
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Downstream consumer of the VGA timing generator's counterX/counterY/hSync/vSync.
- Fetches 32-bit framebuffer words from a read-only memory port into a prefetch FIFO, unpacks four RGB332 pixels per word and drives registered colour outputs.
- Delays the syncs to match the colour pipeline.
- Sits between the timing generator and the DAC/HDMI encoder pins.

Parameters:
- H_ACTIVE, 800, visible pixels per line; must be a multiple of 4 and ≤1024.
- V_ACTIVE, 600, visible lines per frame; must be ≤768.
- ADDR_W, 20, framebuffer word-address width.
- FIFO_DEPTH, 8, prefetch FIFO depth in words; power of 2, ≥4.
- UNDERFLOW_COLOR, 8'hE3, RGB332 value shown when the FIFO is empty during active video.

Ports:
- c  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- counterX  in  10  horizontal position, 0..1023, wraps
- counterY  in  10  vertical position, 0..767, increments when counterX==1023
- hSync_in  in  1  horizontal sync from timing generator
- vSync_in  in  1  vertical sync from timing generator
- fb_base  in  ADDR_W  framebuffer word base address; sampled at frame end
- mem_req  out  1  read request valid
- mem_addr  out  ADDR_W  word address; stable while mem_req && !mem_ready
- mem_ready  in  1  request accepted this cycle when mem_req is high
- mem_rvalid  in  1  read data valid; in-order, arbitrary latency ≥1
- mem_rdata  in  32  read data
- red  out  3  pixel red
- green  out  3  pixel green
- blue  out  2  pixel blue
- de  out  1  data enable (active video)
- hSync_out  out  1  hSync_in delayed 2 cycles
- vSync_out  out  1  vSync_in delayed 2 cycles
- underflow  out  1  sticky underflow flag

Behaviour:
- Reset (rst_n low at posedge c):
  - All outputs 0: red, green, blue, de, mem_req, mem_addr, underflow.
  - hSync_out and vSync_out are 1 (idle-high).
  - FIFO empty; outstanding=0; state IDLE.
- frame_end = (counterX==1023 && counterY==767).
- active = (counterX < H_ACTIVE && counterY < V_ACTIVE).
- FSM states:
  - IDLE: mem_req=0. On frame_end → RUN, performing the frame-start load.
  - RUN: issue requests. On frame_end:
    - If outstanding==0, do the frame-start load and stay in RUN.
    - Otherwise, flush the FIFO, set drop_cnt=outstanding, deassert mem_req → DRAIN.
  - DRAIN: each mem_rvalid is discarded and decrements drop_cnt. When drop_cnt reaches 0 (including on the same cycle as the last rvalid), do the frame-start load → RUN.
- Frame-start load:
  - mem_addr ← fb_base.
  - words_left ← H_ACTIVE*V_ACTIVE/4.
  - FIFO cleared.
- Request rule in RUN: mem_req = (words_left != 0) && (fifo_count + outstanding < FIFO_DEPTH).
  - On mem_req && mem_ready: mem_addr+1, words_left−1, outstanding+1.
  - mem_addr wraps modulo 2^ADDR_W.
- Response in RUN: mem_rvalid pushes mem_rdata and decrements outstanding. A push and a pop in the same cycle keep fifo_count unchanged.
  - The request rule guarantees the FIFO never overflows.
  - A response arriving with outstanding==0 is a protocol error and is ignored.
- Pixel pipeline, stage 1 (registered from the counters):
  - Registers active, sel=counterX[1:0], and the syncs.
  - If active and the FIFO is non-empty, latch byte sel of the FIFO head. Pixel 0 is bits [7:0]; pixel 3 is bits [31:24].
  - Pop the head when active && sel==3 && non-empty.
- Stage 2: register the outputs.
  - The byte maps to red=[7:5], green=[4:2], blue=[1:0].
  - de = stage-1 active.
  - Blanking outputs colour 0.
- Latency: exactly 2 cycles from counter/sync inputs to red/green/blue/de/hSync_out/vSync_out.
- Underflow: active pixel with the FIFO empty outputs UNDERFLOW_COLOR, sets underflow=1, and performs no pop.
  - The next word that arrives serves the next pixel position; misalignment is accepted until the next frame flush.
  - underflow clears only on reset.
- Simultaneous frame_end and a response in RUN: the flush wins, and the response counts toward drop_cnt. This means drop_cnt = outstanding − 1 when that rvalid coincides.
- Reset mid-operation: immediate return to IDLE. In-flight responses arriving after reset are ignored because outstanding is 0 in IDLE, where rvalid is ignored.

Decomposition:
- Shared package vga_pkg holds:
  - H_COUNT_MAX=1023 and V_COUNT_MAX=767.
  - The RGB332 field positions.
  - The state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
- One sub-module, scanout_fifo: synchronous 32-bit FIFO parameterised by FIFO_DEPTH.
  - Ports: push, pop, data, count, empty, flush.
  - Flush has priority over push and pop.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs → all outputs 0 except hSync_out=vSync_out=1; mem_req=0.
- Nominal scanout: mem_ready=1, 1-cycle rvalid latency, fb_base=0, mem_rdata=addr-based pattern such that word 0 = 32'h1C03E0FF.
  - At counter (0,0) of frame 2, the outputs two cycles later show pixels FF, E0, 03, 1C in order: (7,7,3), (7,0,0), (0,0,3), (0,7,0).
  - de=1.
- Blanking: counterX=H_ACTIVE (800), counterY=10 → two cycles later de=0, rgb=0.
- Stalled memory: mem_ready=0 throughout the frame → at the first active pixel the colour equals E3, i.e. (7,0,3), and underflow=1 and stays 1 after mem_ready returns.
- Flush with outstanding reads: 20-cycle rvalid latency; frame_end while 5 reads are outstanding → DRAIN; 5 discarded rvalids; first request of the new frame at address fb_base.
- Sync alignment: toggle hSync_in and vSync_in at random cycles → hSync_out and vSync_out match them delayed exactly 2 cycles.
